// File: rtl/decoder_dispatch_pkg.sv
// Shared types and helpers for the decoder dispatch slice: FSM state
// encodings for the input and output sides and the beat-count helper.
package decoder_dispatch_pkg;

    // Input side: waiting for a frame start, or loading the remaining beats
    typedef enum logic {
        IN_IDLE = 1'b0,
        IN_LOAD = 1'b1
    } inState_t;

    // Output side: waiting for the in-order decoder, or moving its beats out
    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_XFER = 1'b1
    } outState_t;

    // Number of beats needed to carry 'bits' items at 'perBeat' per beat
    function automatic int beatsFor(input int bits, input int perBeat);
        return (bits - 1) / perBeat + 1;
    endfunction

endpackage

// File: rtl/decoder_out_collector.sv
// Output side of the dispatcher: serves decoders strictly in rd_ptr order,
// copies the selected decoder's beats into the output register and pulses
// drain_done on the last beat so the top can retire the frame.
module decoder_out_collector
    import decoder_dispatch_pkg::*;
#(
    parameter int N_DEC     = 4,
    parameter int WIDTH_OUT = 4,
    parameter int OUT_BEATS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_DEC-1:0]           i_dec_out_ready,
    input  logic [N_DEC-1:0]           i_dec_data_valid_out,
    input  logic [N_DEC*WIDTH_OUT-1:0] i_dec_databus_out,
    output logic [N_DEC-1:0]           o_dec_first_data_out,
    output logic [WIDTH_OUT-1:0]       o_out_data,
    output logic                       o_out_valid,
    output logic                       o_out_first,
    output logic                       o_drain_done
);

    localparam int PTR_W  = $clog2(N_DEC);
    localparam int BEAT_W = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(N_DEC - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(OUT_BEATS - 1);

    outState_t            r_state;
    outState_t            w_stateNext;
    logic [PTR_W-1:0]     r_rdPtr;
    logic [PTR_W-1:0]     w_rdPtrNext;
    logic [BEAT_W-1:0]    r_beat;
    logic [BEAT_W-1:0]    w_beatNext;
    logic                 w_beatTake;
    logic [WIDTH_OUT-1:0] w_slice [N_DEC];
    logic [WIDTH_OUT-1:0] r_outData;
    logic                 r_outValid;
    logic                 r_outFirst;

    // Split the concatenated decoder buses so the read pointer can pick one
    for (genvar gi = 0; gi < N_DEC; gi++) begin : gSlice
        assign w_slice[gi] = i_dec_databus_out[gi*WIDTH_OUT +: WIDTH_OUT];
    end

    // Next-state logic: start a drain only from idle, take beats only from rd_ptr
    always_comb begin
        w_stateNext          = r_state;
        w_rdPtrNext          = r_rdPtr;
        w_beatNext           = r_beat;
        w_beatTake           = 1'b0;
        o_dec_first_data_out = '0;
        o_drain_done         = 1'b0;
        case (r_state)
            OUT_IDLE: begin
                if (i_dec_out_ready[r_rdPtr]) begin
                    o_dec_first_data_out[r_rdPtr] = 1'b1;
                    w_beatNext                    = '0;
                    w_stateNext                   = OUT_XFER;
                end
            end
            OUT_XFER: begin
                if (i_dec_data_valid_out[r_rdPtr]) begin
                    w_beatTake = 1'b1;
                    if (r_beat == LAST_BEAT) begin
                        w_beatNext   = '0;
                        w_stateNext  = OUT_IDLE;
                        o_drain_done = 1'b1;
                        w_rdPtrNext  = (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + 1'b1;
                    end else begin
                        w_beatNext = r_beat + 1'b1;
                    end
                end
            end
            default: w_stateNext = OUT_IDLE;
        endcase
    end

    // State, read pointer and beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= OUT_IDLE;
            r_rdPtr <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_stateNext;
            r_rdPtr <= w_rdPtrNext;
            r_beat  <= w_beatNext;
        end
    end

    // Output register: one beat per accepted decoder beat, first flag on beat 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outData  <= '0;
            r_outValid <= 1'b0;
            r_outFirst <= 1'b0;
        end else begin
            r_outValid <= w_beatTake;
            if (w_beatTake) begin
                r_outData  <= w_slice[r_rdPtr];
                r_outFirst <= (r_beat == '0);
            end else begin
                r_outFirst <= 1'b0;
            end
        end
    end

    assign o_out_data  = r_outData;
    assign o_out_valid = r_outValid;
    assign o_out_first = r_outFirst;

endmodule

// File: rtl/decoder_dispatch.sv
// Frame scheduler in front of a bank of decoders: hands each incoming frame
// to the next decoder in round-robin order and drains results in arrival
// order through the output collector, tracking frames in flight.
module decoder_dispatch
    import decoder_dispatch_pkg::*;
#(
    parameter int N_DEC     = 4,
    parameter int WIDTH_IN  = 4,
    parameter int N_LLRS    = 4,
    parameter int WIDTH_OUT = 4,
    parameter int N_V       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_LLRS*WIDTH_IN-1:0]   i_in_data,
    input  logic                         i_in_first,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    output logic [N_LLRS*WIDTH_IN-1:0]   o_dec_databus_in,
    output logic [N_DEC-1:0]             o_dec_first_data,
    output logic [N_DEC-1:0]             o_dec_data_valid,
    input  logic [N_DEC-1:0]             i_dec_busy,
    input  logic [N_DEC-1:0]             i_dec_out_ready,
    output logic [N_DEC-1:0]             o_dec_first_data_out,
    input  logic [N_DEC*WIDTH_OUT-1:0]   i_dec_databus_out,
    input  logic [N_DEC-1:0]             i_dec_data_valid_out,
    output logic [WIDTH_OUT-1:0]         o_out_data,
    output logic                         o_out_valid,
    output logic                         o_out_first,
    output logic [$clog2(N_DEC+1)-1:0]   o_inflight
);

    localparam int IN_BEATS  = beatsFor(N_V, N_LLRS);
    localparam int OUT_BEATS = beatsFor(N_V, WIDTH_OUT);
    localparam int PTR_W     = $clog2(N_DEC);
    localparam int CNT_W     = $clog2(N_DEC + 1);
    localparam int IN_BEAT_W = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
    localparam logic [PTR_W-1:0]     LAST_PTR     = PTR_W'(N_DEC - 1);
    localparam logic [IN_BEAT_W-1:0] LAST_IN_BEAT = IN_BEAT_W'(IN_BEATS - 1);
    localparam logic [CNT_W-1:0]     FULL         = CNT_W'(N_DEC);

    inState_t             r_inState;
    inState_t             w_inStateNext;
    logic [IN_BEAT_W-1:0] r_inBeat;
    logic [IN_BEAT_W-1:0] w_inBeatNext;
    logic [PTR_W-1:0]     r_wrPtr;
    logic [CNT_W-1:0]     r_inflight;
    logic                 w_inReady;
    logic                 w_frameClose;
    logic                 w_drainDone;

    assign o_dec_databus_in = i_in_data;
    assign o_in_ready       = w_inReady;
    assign o_inflight       = r_inflight;

    // Input FSM: accept a frame start only into a free decoder with room in
    // flight, then stream the remaining beats to that same decoder
    always_comb begin
        w_inStateNext    = r_inState;
        w_inBeatNext     = r_inBeat;
        w_inReady        = 1'b0;
        w_frameClose     = 1'b0;
        o_dec_first_data = '0;
        o_dec_data_valid = '0;
        case (r_inState)
            IN_IDLE: begin
                w_inReady = !rst && !i_dec_busy[r_wrPtr] && (r_inflight != FULL);
                if (i_in_valid && w_inReady && i_in_first) begin
                    o_dec_first_data[r_wrPtr] = 1'b1;
                    o_dec_data_valid[r_wrPtr] = 1'b1;
                    if (IN_BEATS == 1) begin
                        w_frameClose = 1'b1;
                    end else begin
                        w_inStateNext = IN_LOAD;
                        w_inBeatNext  = IN_BEAT_W'(1);
                    end
                end
            end
            IN_LOAD: begin
                w_inReady = 1'b1;
                if (i_in_valid) begin
                    o_dec_data_valid[r_wrPtr] = 1'b1;
                    if (r_inBeat == LAST_IN_BEAT) begin
                        w_frameClose  = 1'b1;
                        w_inBeatNext  = '0;
                        w_inStateNext = IN_IDLE;
                    end else begin
                        w_inBeatNext = r_inBeat + 1'b1;
                    end
                end
            end
            default: w_inStateNext = IN_IDLE;
        endcase
    end

    // Input FSM registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inState <= IN_IDLE;
            r_inBeat  <= '0;
        end else begin
            r_inState <= w_inStateNext;
            r_inBeat  <= w_inBeatNext;
        end
    end

    // Write pointer advances on each closed frame; in-flight count nets out a
    // close and a drain landing in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr    <= '0;
            r_inflight <= '0;
        end else begin
            if (w_frameClose) begin
                r_wrPtr <= (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + 1'b1;
            end
            case ({w_frameClose, w_drainDone})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    decoder_out_collector #(
        .N_DEC     (N_DEC),
        .WIDTH_OUT (WIDTH_OUT),
        .OUT_BEATS (OUT_BEATS)
    ) uCollector (
        .clk                  (clk),
        .rst                  (rst),
        .i_dec_out_ready      (i_dec_out_ready),
        .i_dec_data_valid_out (i_dec_data_valid_out),
        .i_dec_databus_out    (i_dec_databus_out),
        .o_dec_first_data_out (o_dec_first_data_out),
        .o_out_data           (o_out_data),
        .o_out_valid          (o_out_valid),
        .o_out_first          (o_out_first),
        .o_drain_done         (w_drainDone)
    );

endmodule
